// File: rtl/read_sel_pkg.sv
// Shared types and defaults for the read selector: FSM states, the length-width
// helper and the default source address map.
package read_sel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int DEF_N_SRC  = 6;
  localparam int DEF_ADDR_W = 8;

  // Source 0 occupies the least significant ADDR_W bits.
  localparam logic [DEF_N_SRC*DEF_ADDR_W-1:0] DEF_SRC_BASE =
    {8'h02, 8'h36, 8'h26, 8'h23, 8'h20, 8'h00};
  localparam logic [DEF_N_SRC*DEF_ADDR_W-1:0] DEF_SRC_LAST =
    {8'h03, 8'h46, 8'h35, 8'h25, 8'h22, 8'h00};

endpackage

// File: rtl/addr_decoder.sv
// Combinational address-window match: one-hot hit on the lowest-indexed
// source whose [base, last] window contains addr, plus a miss flag.
module addr_decoder
  import read_sel_pkg::*;
#(
  parameter int N_SRC  = DEF_N_SRC,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [N_SRC*ADDR_W-1:0] SRC_BASE = DEF_SRC_BASE,
  parameter logic [N_SRC*ADDR_W-1:0] SRC_LAST = DEF_SRC_LAST
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SRC-1:0]  hit,
  output logic              miss
);

  // An inverted window (base > last) can never satisfy both bounds.
  always_comb begin
    hit  = '0;
    miss = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (miss && (addr >= SRC_BASE[i*ADDR_W +: ADDR_W]) &&
          (addr <= SRC_LAST[i*ADDR_W +: ADDR_W])) begin
        hit[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/read_selector.sv
// Burst read selector: walks an address range one beat at a time, strobes the
// matching source, captures its data and presents it on a valid/ready port.
module read_selector
  import read_sel_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_SRC   = DEF_N_SRC,
  parameter logic [N_SRC*ADDR_W-1:0] SRC_BASE = DEF_SRC_BASE,
  parameter logic [N_SRC*ADDR_W-1:0] SRC_LAST = DEF_SRC_LAST,
  parameter int MAX_LEN = 16,
  localparam int LEN_W  = clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [LEN_W-1:0]        rd_len,
  output logic                    busy,
  output logic [ADDR_W-1:0]       src_addr,
  output logic [N_SRC-1:0]        src_sel,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_err,
  output logic                    rd_last
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    if (len == '0)
      return LEN_ONE;
    else if (len > LEN_MAX)
      return LEN_MAX;
    else
      return len;
  endfunction

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    remaining;
  logic [N_SRC-1:0]    hit;
  logic                miss;
  logic [DATA_W-1:0]   cap_data;

  // The address is held from FETCH through CAPTURE, so the same decode
  // drives both the strobe and the capture mux.
  addr_decoder #(
    .N_SRC    (N_SRC),
    .ADDR_W   (ADDR_W),
    .SRC_BASE (SRC_BASE),
    .SRC_LAST (SRC_LAST)
  ) u_decoder (
    .addr (addr),
    .hit  (hit),
    .miss (miss)
  );

  always_comb begin
    cap_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (hit[i]) cap_data = cap_data | src_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_req) state_nxt = FETCH;
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (rd_ready) state_nxt = (remaining == LEN_ONE) ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            addr      <= rd_addr;
            remaining <= norm_len(rd_len);
          end
        end
        CAPTURE: begin
          rd_data <= miss ? '0 : cap_data;
          rd_err  <= miss;
        end
        HOLD: begin
          if (rd_ready) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - LEN_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign src_addr = addr;
  assign src_sel  = (state == FETCH) ? hit : '0;
  assign rd_valid = (state == HOLD);
  assign rd_last  = (state == HOLD) && (remaining == LEN_ONE);

endmodule

// File: tb/tb_read_selector.sv
// Directed bench for read_selector: hand-computed beats over the default map.
module tb_read_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic [4:0]  rd_len;
  logic        busy;
  logic [7:0]  src_addr;
  logic [5:0]  src_sel;
  logic [47:0] src_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic        rd_err;
  logic        rd_last;

  int n_tests = 0;
  int n_fail  = 0;

  read_selector dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_len   (rd_len),
    .busy     (busy),
    .src_addr (src_addr),
    .src_sel  (src_sel),
    .src_data (src_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .rd_last  (rd_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] a, input logic [4:0] len);
    rd_req  = 1'b1;
    rd_addr = a;
    rd_len  = len;
  endtask

  // One beat: FETCH, CAPTURE, then HOLD (checked, not yet accepted).
  task automatic beat(input string tag, input logic [7:0] ea, input logic [5:0] es,
                      input logic [7:0] ed, input logic ee, input logic el);
    tick();
    rd_req = 1'b0;
    check({tag, " fetch addr"}, src_addr, ea);
    check({tag, " fetch sel"}, src_sel, es);
    check({tag, " fetch busy"}, busy, 1);
    check({tag, " fetch valid"}, rd_valid, 0);
    tick();
    check({tag, " capture sel"}, src_sel, 0);
    check({tag, " capture valid"}, rd_valid, 0);
    tick();
    check({tag, " hold valid"}, rd_valid, 1);
    check({tag, " hold data"}, rd_data, ed);
    check({tag, " hold err"}, rd_err, ee);
    check({tag, " hold last"}, rd_last, el);
  endtask

  task automatic expect_idle(input string tag);
    tick();
    check({tag, " busy"}, busy, 0);
    check({tag, " valid"}, rd_valid, 0);
  endtask

  initial begin
    src_data = {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_ready = 1'b1;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset valid", rd_valid, 0);
    check("reset sel", src_sel, 0);
    check("reset last", rd_last, 0);
    check("reset addr", src_addr, 0);
    check("reset data", rd_data, 0);
    rst = 1'b0;
    tick();

    // Three-beat burst from source 1
    start(8'h20, 5'd3);
    beat("b39.1", 8'h20, 6'b000010, 8'hA1, 0, 0);
    beat("b39.2", 8'h21, 6'b000010, 8'hA1, 0, 0);
    beat("b39.3", 8'h22, 6'b000010, 8'hA1, 0, 1);
    expect_idle("b39 end");

    // Unmapped address
    start(8'h10, 5'd1);
    beat("b40", 8'h10, 6'b000000, 8'h00, 1, 1);
    expect_idle("b40 end");

    // Address wrap into source 0
    start(8'hFF, 5'd2);
    beat("b41.1", 8'hFF, 6'b000000, 8'h00, 1, 0);
    beat("b41.2", 8'h00, 6'b000001, 8'hA0, 0, 1);
    expect_idle("b41 end");

    // Back-pressure in HOLD; rd_req during the stall is ignored
    rd_ready = 1'b0;
    start(8'h23, 5'd2);
    beat("b42.1", 8'h23, 6'b000100, 8'hA2, 0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) start(8'h10, 5'd1);
      if (k == 3) rd_req = 1'b0;
      tick();
      check("b42 stall valid", rd_valid, 1);
      check("b42 stall data", rd_data, 8'hA2);
      check("b42 stall last", rd_last, 0);
      check("b42 stall addr", src_addr, 8'h23);
    end
    rd_ready = 1'b1;
    beat("b42.2", 8'h24, 6'b000100, 8'hA2, 0, 1);
    expect_idle("b42 end");

    // Reset during FETCH of beat 2
    start(8'h26, 5'd4);
    beat("b43.1", 8'h26, 6'b001000, 8'hA3, 0, 0);
    tick();
    check("b43 fetch2 addr", src_addr, 8'h27);
    check("b43 fetch2 sel", src_sel, 6'b001000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("b43 rst busy", busy, 0);
    check("b43 rst sel", src_sel, 0);
    check("b43 rst valid", rd_valid, 0);
    check("b43 rst err", rd_err, 0);
    check("b43 rst last", rd_last, 0);
    check("b43 rst data", rd_data, 0);
    check("b43 rst addr", src_addr, 0);
    expect_idle("b43 post1");
    expect_idle("b43 post2");
    start(8'h36, 5'd1);
    beat("b43 fresh", 8'h36, 6'b010000, 8'hA4, 0, 1);
    expect_idle("b43 fresh end");

    // Length normalisation: 0 -> 1 beat, 21 -> 16 beats
    start(8'h02, 5'd0);
    beat("b44 len0", 8'h02, 6'b100000, 8'hA5, 0, 1);
    expect_idle("b44 len0 end");

    start(8'h36, 5'd21);
    for (int b = 0; b < 16; b++)
      beat($sformatf("b44 clamp.%0d", b), 8'h36 + 8'(b), 6'b010000, 8'hA4, 0, (b == 15));
    expect_idle("b44 clamp end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/read_selector.md
READ_SELECTOR -- requirements
Module: read_selector

Interface
REQ-001 Parameter DATA_W, default 8, width of every read source and of rd_data.
REQ-002 Parameter ADDR_W, default 8, width of the read address.
REQ-003 Parameter N_SRC, default 6, number of read sources, range 1..16.
REQ-004 Parameter SRC_BASE, default {0x00,0x20,0x23,0x26,0x36,0x02}, flattened N_SRC x ADDR_W first address per source.
REQ-005 Parameter SRC_LAST, default {0x00,0x22,0x25,0x35,0x46,0x03}, flattened N_SRC x ADDR_W last address per source, inclusive.
REQ-006 Parameter MAX_LEN, default 16, maximum burst length in beats.
REQ-007 clk  in  1  single clock; all logic is rising-edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 rd_req  in  1  read-request strobe, sampled only in IDLE.
REQ-010 rd_addr  in  ADDR_W  start address of the burst.
REQ-011 rd_len  in  clog2(MAX_LEN+1)  beat count; 0 is treated as 1; values above MAX_LEN are clamped to MAX_LEN.
REQ-012 busy  out  1  high while a burst is in progress.
REQ-013 src_addr  out  ADDR_W  address currently being fetched.
REQ-014 src_sel  out  N_SRC  one-hot strobe of the addressed source, high for one FETCH cycle.
REQ-015 src_data  in  N_SRC x DATA_W  flattened source data, valid one cycle after src_sel.
REQ-016 rd_valid / rd_ready  out / in  1 / 1  output beat handshake.
REQ-017 rd_data  out  DATA_W  beat data.
REQ-018 rd_err  out  1  beat address matched no source.
REQ-019 rd_last  out  1  final beat of the burst.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, CAPTURE and HOLD.
REQ-021 IDLE: on rd_req=1, latch rd_addr and the normalised length, then go to FETCH; otherwise remain in IDLE.
REQ-022 FETCH: drive src_addr and assert the src_sel bit of the lowest-indexed source with SRC_BASE<=addr<=SRC_LAST, then go to CAPTURE.
REQ-023 CAPTURE: register the selected src_data slice into rd_data; if no source matched, load 0 and set rd_err; then go to HOLD.
REQ-024 HOLD: assert rd_valid and keep rd_data, rd_err and rd_last stable until rd_valid&rd_ready is seen.
REQ-025 On the last accepted beat, go to IDLE; otherwise increment the address and go to FETCH.
REQ-026 The address increment SHALL wrap from 2^ADDR_W-1 to 0 with no error.
REQ-027 Latency: with rd_req accepted at cycle T, src_sel is asserted at T+1 and rd_valid at T+3 at the earliest; each following beat is ready 3 cycles after the previous accept.
REQ-028 rd_last = (remaining beats == 1) while in HOLD.
REQ-029 busy = (state != IDLE).
REQ-030 rd_req is ignored while busy=1; it is not queued.
REQ-031 rd_ready is ignored outside HOLD.
REQ-032 Overlapping windows resolve to the lowest source index; windows with SRC_BASE>SRC_LAST never match.

Reset
REQ-033 rst SHALL force state IDLE and clear busy, src_sel, rd_valid, rd_err, rd_last, rd_data, src_addr and the beat counter to 0 on the next clock edge.
REQ-034 Reset asserted mid-burst SHALL abort the burst; no further beats are presented.
REQ-035 Reset SHALL take priority over every other input.

Structure
REQ-036 A shared package read_sel_pkg SHALL hold the FSM state enum, the clog2 length-width function and the default address-map constants.
REQ-037 Address matching SHALL be a sub-module addr_decoder, purely combinational, that outputs a one-hot hit vector plus a miss flag.
REQ-038 The FSM, beat counter and output register SHALL live in read_selector.

Verification
REQ-039 rd_req with addr=0x20, len=3, rd_ready=1, sources loaded with 0xA1 on source 1 -> three beats of 0xA1 at addresses 0x20..0x22; rd_last only on beat 3; busy falls the cycle after beat 3.
REQ-040 rd_req with addr=0x10, len=1 -> one beat, rd_data=0x00, rd_err=1, rd_last=1, no src_sel bit asserted.
REQ-041 rd_req with addr=0xFF, len=2 -> beats at src_addr 0xFF then 0x00; beat 2 returns source 0 data with rd_err=0.
REQ-042 rd_ready held low for 5 cycles in HOLD -> rd_valid, rd_data and rd_last stay constant, and a new rd_req in that window is ignored.
REQ-043 rst pulsed during FETCH of beat 2 of a len=4 burst -> next cycle all outputs are 0 and state is IDLE; a fresh request then completes normally.
REQ-044 rd_len=0 and rd_len=MAX_LEN+5 -> exactly 1 and MAX_LEN beats respectively.
